speed_search: RTL and testbench

SPEED_SEARCH -- requirements
Module: speed_search

---
 rtl/speed_search.sv | 201 ++++++++++++++++++++
 tb/tb_speed_search.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/speed_search.sv
// Bisection search for the launch speed whose computed ground range lands within
// TOL of a target distance, driving an external range stage through a speed/ctrl/range_rdy handshake.
module speed_search #(
  parameter logic [31:0] SPEED_MAX = 32'd100000,
  parameter logic [31:0] TOL       = 32'd50,
  parameter int unsigned MAX_ITER  = 40,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] target,
  output logic [31:0] speed,
  output logic        ctrl,
  input  logic [31:0] range_in,
  input  logic        range_rdy,
  output logic [31:0] best_speed,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic        fail,
  output logic        err
);

  localparam int unsigned IW = $clog2(MAX_ITER + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        r_state;
  logic [31:0]   r_target;
  logic [31:0]   r_range;
  logic [32:0]   r_lo;
  logic [31:0]   r_hi;
  logic [IW-1:0] r_iter;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_speed;
  logic          r_ctrl;
  logic [31:0]   r_best;
  logic          r_busy;
  logic          r_done;
  logic          r_hit;
  logic          r_fail;
  logic          r_err;

  logic          w_range_ge;
  logic [32:0]   w_err;
  logic          w_within;
  logic          w_first;
  logic [IW-1:0] w_iter_nx;
  logic [32:0]   w_lo_nx;
  logic [31:0]   w_hi_nx;
  logic [32:0]   w_sum;
  logic [31:0]   w_mid;
  logic          w_exhaust;

  assign speed      = r_speed;
  assign ctrl       = r_ctrl;
  assign best_speed = r_best;
  assign busy       = r_busy;
  assign done       = r_done;
  assign hit        = r_hit;
  assign fail       = r_fail;
  assign err        = r_err;

  // Evaluation of the probe currently held in r_speed against the captured target
  assign w_range_ge = (r_range >= r_target);
  assign w_err      = w_range_ge ? ({1'b0, r_range} - {1'b0, r_target})
                                 : ({1'b0, r_target} - {1'b0, r_range});
  assign w_within   = (w_err <= {1'b0, TOL});
  assign w_first    = (r_iter == '0);
  assign w_iter_nx  = r_iter + IW'(1);

  // Window update; the first probe at SPEED_MAX leaves the full window in place
  always_comb begin
    w_lo_nx = r_lo;
    w_hi_nx = r_hi;
    if (!w_first && !w_within) begin
      if (!w_range_ge) w_lo_nx = {1'b0, r_speed} + 33'd1;
      else             w_hi_nx = r_speed - 32'd1;
    end
  end

  assign w_sum     = {1'b0, w_lo_nx[31:0]} + {1'b0, w_hi_nx};
  assign w_mid     = 32'(w_sum >> 1);
  assign w_exhaust = (w_lo_nx > {1'b0, w_hi_nx}) || (w_iter_nx == IW'(MAX_ITER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_range  <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_iter   <= '0;
      r_tcnt   <= '0;
      r_speed  <= '0;
      r_ctrl   <= 1'b0;
      r_best   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hit    <= 1'b0;
      r_fail   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= target;
            r_lo     <= '0;
            r_hi     <= SPEED_MAX;
            r_iter   <= '0;
            r_hit    <= 1'b0;
            r_fail   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_speed  <= SPEED_MAX;
            r_ctrl   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_ctrl  <= 1'b0;
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end

        // Timeout is checked first so a range_rdy on the expiring edge is dropped
        S_WAIT: begin
          if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (range_rdy) begin
            r_range <= range_in;
            r_state <= S_EVAL;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end

        S_EVAL: begin
          r_iter <= w_iter_nx;
          r_lo   <= w_lo_nx;
          r_hi   <= w_hi_nx;
          if (w_first) begin
            r_best <= SPEED_MAX;
            if (!w_range_ge && !w_within) begin
              r_fail  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if (w_exhaust) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_speed <= w_mid;
              r_ctrl  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end else if (w_within) begin
            r_best  <= r_speed;
            r_hit   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            if (w_range_ge) r_best <= r_speed;
            if ((w_range_ge && (r_speed == '0)) || w_exhaust) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_speed <= w_mid;
              r_ctrl  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_ctrl  <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speed_search.sv
// Scoreboard bench for speed_search: a range stage returning 2*speed three cycles
// after ctrl, with expected results queued at launch and checked on each done pulse.
module tb_speed_search;

  localparam logic [31:0] SPEED_MAX = 32'd100000;
  localparam logic [31:0] TOL       = 32'd50;
  localparam int unsigned MAX_ITER  = 40;
  localparam int unsigned TIMEOUT   = 1024;
  localparam int          BOUND     = 5 * MAX_ITER + TIMEOUT + 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] speed;
  logic        ctrl;
  logic [31:0] range_in;
  logic        range_rdy;
  logic [31:0] best_speed;
  logic        busy, done, hit, fail, err;
  logic        mute = 1'b0;
  logic [2:0]  r_dly;

  speed_search #(
    .SPEED_MAX(SPEED_MAX), .TOL(TOL), .MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .speed(speed), .ctrl(ctrl), .range_in(range_in), .range_rdy(range_rdy),
    .best_speed(best_speed), .busy(busy), .done(done), .hit(hit),
    .fail(fail), .err(err)
  );

  always #5 clk = ~clk;

  // Range stage: range_rdy in the third cycle after the ctrl cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dly <= '0;
    else        r_dly <= {r_dly[1:0], ctrl};
  end
  assign range_rdy = r_dly[2] & ~mute;
  assign range_in  = speed << 1;

  typedef struct {
    logic [31:0] best;
    logic        hit;
    logic        fail;
    logic        err;
    int          probes;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          ctrl_cnt = 0;
  logic        prev_done = 1'b0;
  logic [31:0] exp_prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference bisection: result, probe count and start-to-done latency
  function automatic exp_t model(input logic [31:0] tgt, input logic [31:0] prev, input bit to);
    exp_t   r;
    longint lo, hi, p, rng, e, t;
    r.best = prev; r.hit = 1'b0; r.fail = 1'b0; r.err = 1'b0; r.probes = 0;
    if (to) begin
      r.err = 1'b1; r.probes = 1; r.lat = int'(TIMEOUT) + 2;
      return r;
    end
    t = longint'(tgt); lo = 0; hi = longint'(SPEED_MAX); p = hi;
    for (int it = 1; it <= int'(MAX_ITER); it++) begin
      r.probes = it;
      rng = 2 * p;
      e = (rng >= t) ? rng - t : t - rng;
      if (it == 1) begin
        r.best = SPEED_MAX;
        if (rng < t && e > longint'(TOL)) begin r.fail = 1'b1; break; end
      end else if (e <= longint'(TOL)) begin
        r.best = 32'(p); r.hit = 1'b1; break;
      end else if (rng < t) begin
        lo = p + 1;
      end else begin
        r.best = 32'(p);
        if (p == 0) break;
        hi = p - 1;
      end
      if (lo > hi || it == int'(MAX_ITER)) break;
      p = (lo + hi) / 2;
    end
    r.lat = 5 * r.probes + 1;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop the expectation on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (ctrl) ctrl_cnt++;
    if (done) begin
      chk("done_single", 32'(prev_done), 32'd0);
      chk("sb_depth", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("best_speed", best_speed, e.best);
        chk("hit", 32'(hit), 32'(e.hit));
        chk("fail", 32'(fail), 32'(e.fail));
        chk("err", 32'(err), 32'(e.err));
        chk("ctrl_pulses", 32'(ctrl_cnt), 32'(e.probes));
        chk("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
      end
      ctrl_cnt = 0;
    end
    prev_done = done;
  end

  task automatic push_exp(input logic [31:0] tgt, input bit to, output exp_t e);
    e = model(tgt, exp_prev, to);
    exp_prev = e.best;
    sb_q.push_back(e);
  endtask

  task automatic launch(input logic [31:0] tgt, input bit to, output exp_t e);
    push_exp(tgt, to, e);
    target = tgt;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  // Results must stay put in IDLE after done
  task automatic run(input logic [31:0] tgt, input bit to);
    exp_t e;
    launch(tgt, to, e);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_best", best_speed, e.best);
    chk("hold_flags", 32'({hit, fail, err}), 32'({e.hit, e.fail, e.err}));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_speed"}, speed, 32'd0);
    chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
    chk({tag, "_best"}, best_speed, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_hit"}, 32'(hit), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] first_best;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'd10000, 1'b0);
    first_best = best_speed;
    chk("hit_10k", 32'(hit), 32'd1);
    chk("window_10k", 32'(best_speed >= 32'd4975 && best_speed <= 32'd5025), 32'd1);

    run(32'd300000, 1'b0);
    chk("fail_300k", 32'(fail), 32'd1);
    chk("best_300k", best_speed, 32'd100000);

    run(32'd0, 1'b0);
    chk("hit_0", 32'(hit), 32'd1);
    chk("small_0", 32'(best_speed <= 32'd25), 32'd1);

    mute = 1'b1;
    run(32'd10000, 1'b1);
    chk("err_to", 32'(err), 32'd1);
    mute = 1'b0;

    // Asynchronous reset in the second WAIT
    launch(32'd10000, 1'b0, e);
    while (cyc - start_cyc < 8) @(negedge clk);
    chk("busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    sb_q.delete();
    ctrl_cnt = 0;
    exp_prev = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run(32'd10000, 1'b0);
    chk("repro_10k", best_speed, first_best);

    // start held high; target changes mid-search
    push_exp(32'd10000, 1'b0, e);
    target = 32'd10000;
    start = 1'b1;
    start_cyc = cyc;
    repeat (12) @(negedge clk);
    target = 32'd300000;
    wait_done();
    @(negedge clk);
    chk("idle_between", 32'(busy), 32'd0);
    push_exp(32'd300000, 1'b0, e);
    start_cyc = cyc;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("held_second_best", best_speed, 32'd100000);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
